// File: rtl/bidir_pin_pkg.sv
// bidir_pin_pkg: shared state encoding, direction constants and counter sizing for bidir_pin_ctrl
package bidir_pin_pkg;
    typedef enum logic [1:0] {IDLE, GUARD, SHIFT_TX, SHIFT_RX} state_t;
    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;
    function automatic int cnt_width(int bits, int turn);
        return $clog2((bits > turn ? bits : turn) + 1);
    endfunction
endpackage

// File: rtl/bidir_pin_ctrl_if.sv
// bidir_pin_ctrl_if: requester handshakes plus bidir_pin control; BIDIR_PARITY_EN adds rx_parity_err
interface bidir_pin_ctrl_if #(parameter int W = 8);
    logic tx_valid, tx_ready, rx_req, rx_ready, rx_valid;
    logic dir, data_out, data_in, busy;
    logic [W-1:0] tx_data, rx_data;
`ifdef BIDIR_PARITY_EN
    logic rx_parity_err;
`endif
    modport master(
        output tx_valid, tx_data, rx_req, data_in,
`ifdef BIDIR_PARITY_EN
        input rx_parity_err,
`endif
        input tx_ready, rx_ready, rx_valid, rx_data, dir, data_out, busy
    );
    modport slave(
        input tx_valid, tx_data, rx_req, data_in,
`ifdef BIDIR_PARITY_EN
        output rx_parity_err,
`endif
        output tx_ready, rx_ready, rx_valid, rx_data, dir, data_out, busy
    );
endinterface

// File: rtl/bidir_rr_arb2.sv
// bidir_rr_arb2: two-requester round-robin arbiter, combinational grant while enabled
module bidir_rr_arb2 import bidir_pin_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_tx,
    input  logic req_rx,
    output logic gnt_tx,
    output logic gnt_rx
);
    logic last_grant;
    always_comb begin
        gnt_tx = en & req_tx & (~req_rx | (last_grant == DIR_RX));
        gnt_rx = en & req_rx & (~req_tx | (last_grant == DIR_TX));
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) last_grant <= DIR_RX;
        else if (gnt_tx | gnt_rx) last_grant <= gnt_tx ? DIR_TX : DIR_RX;
endmodule

// File: rtl/bidir_pin_ctrl.sv
// bidir_pin_ctrl: half-duplex MSB-first word serialiser/deserialiser with turnaround guard
// BIDIR_PARITY_EN appends an even-parity bit to every word and reports rx_parity_err
module bidir_pin_ctrl import bidir_pin_pkg::*; #(
    parameter int W = 8,
    parameter int TURN_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    bidir_pin_ctrl_if.slave bus
);
`ifdef BIDIR_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    localparam int CW = cnt_width(NB, TURN_CYCLES);
    localparam logic [CW-1:0] BIT_LAST = CW'(NB - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);
    state_t state, state_n;
    logic last_dir, grant_dir, gnt_tx, gnt_rx, rx_valid_q;
    logic [NB-1:0] sr, load, rx_word;
    logic [CW-1:0] cnt;
    logic [W-1:0] rx_data_q;
    wire bit_done = cnt == BIT_LAST;
    wire turn_done = cnt == TURN_LAST;
    bidir_rr_arb2 u_arb (
        .clk(clk), .rst(rst), .en(state == IDLE),
        .req_tx(bus.tx_valid), .req_rx(bus.rx_req),
        .gnt_tx(gnt_tx), .gnt_rx(gnt_rx)
    );
`ifdef BIDIR_PARITY_EN
    logic perr_q;
    assign load = {bus.tx_data, ^bus.tx_data};
    assign bus.rx_parity_err = perr_q;
`else
    assign load = bus.tx_data;
`endif
    assign rx_word = {sr[NB-2:0], bus.data_in};
    assign bus.tx_ready = gnt_tx;
    assign bus.rx_ready = gnt_rx;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data = rx_data_q;
    always_comb begin
        state_n = state;
        bus.busy = state != IDLE;
        bus.dir = state == SHIFT_TX;
        bus.data_out = (state == SHIFT_TX) & sr[NB-1];
        case (state)
            IDLE: if (gnt_tx | gnt_rx)
                state_n = (gnt_tx != last_dir && TURN_CYCLES > 0) ? GUARD : gnt_tx ? SHIFT_TX : SHIFT_RX;
            GUARD: if (turn_done) state_n = (grant_dir == DIR_TX) ? SHIFT_TX : SHIFT_RX;
            SHIFT_TX, SHIFT_RX: if (bit_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last_dir <= DIR_RX;
            grant_dir <= DIR_RX;
            sr <= '0;
            cnt <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q <= '0;
`ifdef BIDIR_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: if (gnt_tx | gnt_rx) begin
                    grant_dir <= gnt_tx ? DIR_TX : DIR_RX;
                    sr <= gnt_tx ? load : '0;
                    cnt <= '0;
                end
                GUARD: begin
                    cnt <= turn_done ? '0 : cnt + 1'b1;
                    if (turn_done) last_dir <= grant_dir;
                end
                SHIFT_TX: begin
                    sr <= sr << 1;
                    cnt <= cnt + 1'b1;
                    if (bit_done) last_dir <= DIR_TX;
                end
                SHIFT_RX: begin
                    sr <= rx_word;
                    cnt <= cnt + 1'b1;
                    if (bit_done) begin
                        last_dir <= DIR_RX;
                        rx_valid_q <= 1'b1;
                        rx_data_q <= rx_word[NB-1 -: W];
`ifdef BIDIR_PARITY_EN
                        perr_q <= ^rx_word;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bidir_pin_ctrl.sv
// tb_bidir_pin_ctrl: vector table, corner sequences and randomized transactions vs a transaction-level model
module tb_bidir_pin_ctrl;
    localparam int W = 8;
    localparam int T = 2;
`ifdef BIDIR_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif
    logic clk = 1'b0, rst = 1'b0, clk_en = 1'b0;
    int checks = 0, errors = 0;
    logic m_last_grant, m_last_dir, last_bit;
    always #5 if (clk_en) clk = ~clk;
    bidir_pin_ctrl_if #(.W(W)) bus();
    bidir_pin_ctrl #(.W(W), .TURN_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    typedef struct packed {
        logic tv, rr, din, txr, rxr, dir, dout, busy, rxv;
        logic [7:0] rxd;
    } vec_t;
    vec_t vecs [32];
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_last_grant = 1'b0;
        m_last_dir = 1'b0;
    endtask
    // One word: grant by round-robin rule, guard on direction change, NB bit cycles, then one IDLE cycle
    task automatic txn(input logic want_tx, input logic want_rx, input logic [W-1:0] td, input logic [NB-1:0] rbits);
        logic g;
        int guard;
        logic [NB-1:0] tbits;
`ifdef BIDIR_PARITY_EN
        tbits = {td, ^td};
`else
        tbits = td;
`endif
        g = (want_tx && want_rx) ? ~m_last_grant : want_tx;
        guard = (g != m_last_dir) ? T : 0;
        bus.tx_valid = want_tx;
        bus.rx_req = want_rx;
        bus.tx_data = td;
        #1;
        chk1("tx_ready", bus.tx_ready, g);
        chk1("rx_ready", bus.rx_ready, ~g);
        chk1("busy_idle", bus.busy, 1'b0);
        m_last_grant = g;
        step();
        for (int i = 0; i < guard; i++) begin
            bus.tx_valid = 1'($urandom);
            bus.rx_req = 1'($urandom);
            bus.data_in = 1'($urandom);
            #1;
            chk1("guard_dir", bus.dir, 1'b0);
            chk1("guard_dout", bus.data_out, 1'b0);
            chk1("guard_busy", bus.busy, 1'b1);
            chk1("guard_ready", bus.tx_ready | bus.rx_ready, 1'b0);
            step();
        end
        for (int i = 0; i < NB; i++) begin
            bus.tx_valid = 1'($urandom);
            bus.rx_req = 1'($urandom);
            bus.data_in = g ? 1'($urandom) : rbits[NB-1-i];
            #1;
            chk1("shift_dir", bus.dir, g);
            if (g) chk1("shift_bit", bus.data_out, tbits[NB-1-i]);
            last_bit = bus.data_out;
            chk1("shift_busy", bus.busy, 1'b1);
            chk1("shift_ready", bus.tx_ready | bus.rx_ready, 1'b0);
            step();
        end
        bus.tx_valid = 1'b0;
        bus.rx_req = 1'b0;
        #1;
        chk1("end_busy", bus.busy, 1'b0);
        chk1("end_dir", bus.dir, 1'b0);
        chk1("end_rx_valid", bus.rx_valid, ~g);
        if (!g) chkw("end_rx_data", bus.rx_data, rbits[NB-1 -: W]);
`ifdef BIDIR_PARITY_EN
        if (!g) chk1("end_perr", bus.rx_parity_err, ^rbits);
`endif
        m_last_dir = g;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int k;
        logic exp_g;
        bus.tx_valid = 1'b0;
        bus.rx_req = 1'b0;
        bus.tx_data = '0;
        bus.data_in = 1'b0;
        #5 rst = 1'b1;
        #1;
        chk1("rst_dir", bus.dir, 1'b0);
        chk1("rst_dout", bus.data_out, 1'b0);
        chk1("rst_tx_ready", bus.tx_ready, 1'b0);
        chk1("rst_rx_ready", bus.rx_ready, 1'b0);
        chk1("rst_rx_valid", bus.rx_valid, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chkw("rst_rx_data", bus.rx_data, '0);
        rst = 1'b0;
        #1;
        chk1("post_rst_busy", bus.busy, 1'b0);
        m_last_grant = 1'b0;
        m_last_dir = 1'b0;
        clk_en = 1'b1;
        step();
`ifndef BIDIR_PARITY_EN
        // fields: tv rr din txr rxr dir dout busy rxv | rx_data
        vecs = '{
            {9'b100100000, 8'h00}, {9'b000000010, 8'h00}, {9'b000000010, 8'h00},
            {9'b000001110, 8'h00}, {9'b000001010, 8'h00}, {9'b000001110, 8'h00},
            {9'b000001010, 8'h00}, {9'b000001010, 8'h00}, {9'b000001110, 8'h00},
            {9'b000001010, 8'h00}, {9'b000001110, 8'h00},
            {9'b010010000, 8'h00}, {9'b000000010, 8'h00}, {9'b000000010, 8'h00},
            {9'b000000010, 8'h00}, {9'b000000010, 8'h00}, {9'b001000010, 8'h00},
            {9'b001000010, 8'h00}, {9'b001000010, 8'h00}, {9'b001000010, 8'h00},
            {9'b000000010, 8'h00}, {9'b000000010, 8'h00},
            {9'b010010001, 8'h3C},
            {9'b001000010, 8'h00}, {9'b000000010, 8'h00}, {9'b000000010, 8'h00},
            {9'b000000010, 8'h00}, {9'b000000010, 8'h00}, {9'b000000010, 8'h00},
            {9'b000000010, 8'h00}, {9'b001000010, 8'h00},
            {9'b000000001, 8'h81}
        };
        bus.tx_data = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            bus.tx_valid = vecs[i].tv;
            bus.rx_req = vecs[i].rr;
            bus.data_in = vecs[i].din;
            #1;
            chk1("vec_tx_ready", bus.tx_ready, vecs[i].txr);
            chk1("vec_rx_ready", bus.rx_ready, vecs[i].rxr);
            chk1("vec_dir", bus.dir, vecs[i].dir);
            chk1("vec_dout", bus.data_out, vecs[i].dout);
            chk1("vec_busy", bus.busy, vecs[i].busy);
            chk1("vec_rx_valid", bus.rx_valid, vecs[i].rxv);
            if (vecs[i].rxv) chkw("vec_rx_data", bus.rx_data, vecs[i].rxd);
            step();
        end
        bus.rx_req = 1'b0;
        bus.data_in = 1'b0;
`else
        txn(1'b1, 1'b0, 8'h07, '0);
        chk1("par_tx_bit", last_bit, 1'b1);
        txn(1'b0, 1'b1, '0, 9'b000001110);
        chk1("par_err_bad", bus.rx_parity_err, 1'b1);
        chkw("par_rx_data", bus.rx_data, 8'h07);
        step();
        txn(1'b0, 1'b1, '0, 9'b000001111);
        chk1("par_err_ok", bus.rx_parity_err, 1'b0);
        step();
`endif
        // both requesters held: grants must alternate starting with TX
        do_reset();
        bus.tx_valid = 1'b1;
        bus.rx_req = 1'b1;
        bus.tx_data = 8'h5A;
        for (int n = 0; n < 4; n++) begin
            k = 0;
            #1;
            while (!(bus.tx_ready | bus.rx_ready) && k < 40) begin
                step();
                #1;
                k++;
            end
            exp_g = (n % 2) == 0;
            chk1("cont_seen", k < 40, 1'b1);
            chk1("cont_tx_grant", bus.tx_ready, exp_g);
            chk1("cont_rx_grant", bus.rx_ready, ~exp_g);
            step();
        end
        bus.tx_valid = 1'b0;
        bus.rx_req = 1'b0;
        // reset during bit 4 of a TX releases the pin at once
        do_reset();
        step();
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'hFF;
        #1;
        chk1("mid_tx_ready", bus.tx_ready, 1'b1);
        step();
        bus.tx_valid = 1'b0;
        for (int i = 0; i < T + 4; i++) step();
        chk1("mid_dir_before", bus.dir, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("mid_dir_rst", bus.dir, 1'b0);
        chk1("mid_dout_rst", bus.data_out, 1'b0);
        chk1("mid_busy_rst", bus.busy, 1'b0);
        rst = 1'b0;
        m_last_grant = 1'b0;
        m_last_dir = 1'b0;
        step();
        txn(1'b1, 1'b0, W'($urandom), '0);
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 2);
            txn(k != 1, k != 0, W'($urandom), NB'($urandom));
            step();
            if ($urandom_range(0, 3) == 0) step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
